// File: rtl/issue_steer_if.sv
// ---------------------------------------------------------------------------
// issue_steer_if
// Bundle-in / lanes-out connection of the issue-to-EXE steering register.
//   in_valid   [LANES]       per-slot valid of the offered bundle
//   in_special [LANES]       per-slot special-class (mem/div) flag
//   in_data    [LANES*DW]    per-slot payload, slot i at [i*DW +: DW]
//   in_ready                 bundle fully consumed this cycle
//   out_valid  [LANES]       per-lane valid to EXE
//   out_data   [LANES*DW]    per-lane payload
//   out_slot   [LANES*SW]    original slot index of each lane
//   out_age    [LANES*SW]    program-order rank within issued group
//   out_split                issued group is not the first of its bundle
// master = issue side / testbench, slave = steering register.
// ---------------------------------------------------------------------------
interface issue_steer_if #(
  parameter int LANES = 2,
  parameter int DW    = 192,
  parameter int SW    = $clog2(LANES)
);
  logic [LANES-1:0]    in_valid;
  logic [LANES-1:0]    in_special;
  logic [LANES*DW-1:0] in_data;
  logic                in_ready;
  logic [LANES-1:0]    out_valid;
  logic [LANES*DW-1:0] out_data;
  logic [LANES*SW-1:0] out_slot;
  logic [LANES*SW-1:0] out_age;
  logic                out_split;

  modport master (
    output in_valid, in_special, in_data,
    input  in_ready, out_valid, out_data, out_slot, out_age, out_split
  );

  modport slave (
    input  in_valid, in_special, in_data,
    output in_ready, out_valid, out_data, out_slot, out_age, out_split
  );
endinterface

// File: rtl/issue_steer_reg.sv
// ---------------------------------------------------------------------------
// issue_steer_reg
// Issue-to-EXE pipeline register with lane steering. Each cycle it issues
// the oldest remaining slots of the bundle up to (not including) the second
// remaining special instruction, places the special on SPECIAL_LANE and the
// others on the remaining lanes in program order, and tags each lane with
// its source slot and age. Bundles with several specials drain over several
// cycles; in_ready marks the cycle the last group leaves.
//
// Ports:
//   clk    clock
//   rst    synchronous reset, active-high (dominates flush/stall)
//   flush  discard current bundle and invalidate outputs
//   stall  hold outputs and internal state
//   bus    issue_steer_if.slave (bundle in, lanes out, in_ready)
//
// Build option:
//   ISSUE_STEER_ZERO_INVALID_EN  force out_data of lanes loaded invalid to 0
// ---------------------------------------------------------------------------
module issue_steer_reg #(
  parameter int LANES        = 2,
  parameter int DW           = 192,
  parameter int SPECIAL_LANE = 1,
  parameter int SW           = $clog2(LANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall,
  issue_steer_if.slave  bus
);

  // FIRST: nothing of the current bundle issued yet; CONT: mid-split.
  typedef enum logic {FIRST, CONT} state_t;

  state_t              state_q, state_d;
  logic [LANES-1:0]    done_q, done_d;

  logic [LANES-1:0]    rem;
  logic [LANES-1:0]    grp;
  logic                grp_final;
  logic                seen_special;
  logic                stop_scan;

  logic [LANES-1:0]    lane_vld;
  logic [SW-1:0]       lane_src [LANES];
  logic [SW-1:0]       lane_age [LANES];
  logic [DW-1:0]       lane_data [LANES];

  logic [LANES-1:0]    out_valid_q;
  logic [LANES*DW-1:0] out_data_q;
  logic [LANES*SW-1:0] out_slot_q;
  logic [LANES*SW-1:0] out_age_q;
  logic                out_split_q;

  // -------------------------------------------------------------------------
  // Group selection: scan remaining slots oldest first, stop at the second
  // special so each issued group carries at most one.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    rem          = bus.in_valid & ~done_q;
    grp          = '0;
    seen_special = 1'b0;
    stop_scan    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (rem[i] && !stop_scan) begin
        if (bus.in_special[i]) begin
          if (seen_special) begin
            stop_scan = 1'b1;
          end else begin
            seen_special = 1'b1;
            grp[i]       = 1'b1;
          end
        end else begin
          grp[i] = 1'b1;
        end
      end
    end
    grp_final = (grp == rem);
  end

  // -------------------------------------------------------------------------
  // Placement: special to SPECIAL_LANE, others fill ascending lanes and skip
  // SPECIAL_LANE only when the group actually holds a special.
  // -------------------------------------------------------------------------
  always_comb begin : place
    int rank;
    int ptr;
    rank     = 0;
    ptr      = 0;
    lane_vld = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_src[l] = '0;
      lane_age[l] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (grp[i]) begin
        if (bus.in_special[i]) begin
          lane_vld[SPECIAL_LANE] = 1'b1;
          lane_src[SPECIAL_LANE] = SW'(i);
          lane_age[SPECIAL_LANE] = SW'(rank);
        end else begin
          if (seen_special && ptr == SPECIAL_LANE) ptr++;
          if (ptr < LANES) begin
            lane_vld[ptr] = 1'b1;
            lane_src[ptr] = SW'(i);
            lane_age[ptr] = SW'(rank);
          end
          ptr++;
        end
        rank++;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
`ifdef ISSUE_STEER_ZERO_INVALID_EN
      lane_data[l] = lane_vld[l] ? bus.in_data[int'(lane_src[l])*DW +: DW] : '0;
`else
      lane_data[l] = bus.in_data[int'(lane_src[l])*DW +: DW];
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Bundle tracking FSM (next state) and upstream handshake.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    if (flush) begin
      state_d = FIRST;
      done_d  = '0;
    end else if (!stall) begin
      if (grp_final) begin
        state_d = FIRST;
        done_d  = '0;
      end else begin
        state_d = CONT;
        done_d  = done_q | grp;
      end
    end
  end

  assign bus.in_ready = flush | (~stall & grp_final);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= FIRST;
      done_q      <= '0;
      out_valid_q <= '0;
      // NOTE: the wide payload register is reset too, so EXE never sees
      // stale control bits from before reset.
      out_data_q  <= '0;
      out_slot_q  <= '0;
      out_age_q   <= '0;
      out_split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (flush) begin
        out_valid_q <= '0;
        out_slot_q  <= '0;
        out_age_q   <= '0;
        out_split_q <= 1'b0;
`ifdef ISSUE_STEER_ZERO_INVALID_EN
        out_data_q  <= '0;
`endif
      end else if (!stall) begin
        out_valid_q <= lane_vld;
        out_split_q <= (state_q == CONT);
        for (int l = 0; l < LANES; l++) begin
          out_data_q[l*DW +: DW] <= lane_data[l];
          out_slot_q[l*SW +: SW] <= lane_src[l];
          out_age_q[l*SW +: SW]  <= lane_age[l];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_slot  = out_slot_q;
  assign bus.out_age   = out_age_q;
  assign bus.out_split = out_split_q;

endmodule
